// File: rtl/ws2812_chain_if.sv
// Producer-side bundle for ws2812_chain: frame-buffer write port, frame handshake and serial output.
interface ws2812_chain_if #(
    parameter int unsigned AW = 3
);
    logic          i_Wr_En;
    logic [AW-1:0] i_Wr_Addr;
    logic [23:0]   i_Wr_Data;
    logic [7:0]    i_Brightness;
    logic          i_Start;
    logic          i_Auto;
    logic          o_Led;
    logic          o_Ready;
    logic          o_Frame_Done;

    modport master (
        output i_Wr_En, i_Wr_Addr, i_Wr_Data, i_Brightness, i_Start, i_Auto,
        input  o_Led, o_Ready, o_Frame_Done
    );

    modport slave (
        input  i_Wr_En, i_Wr_Addr, i_Wr_Data, i_Brightness, i_Start, i_Auto,
        output o_Led, o_Ready, o_Frame_Done
    );
endinterface

// File: rtl/ws2812_chain.sv
// WS2812 chain driver: GRB frame buffer, brightness scaling, serialiser with latch gap and auto-refresh.
module ws2812_chain #(
    parameter int unsigned CLOCK_FREQUENCY = 80000000,
    parameter int unsigned NUM_LEDS        = 8,
    parameter int unsigned T0H_NS          = 400,
    parameter int unsigned T1H_NS          = 800,
    parameter int unsigned TBIT_NS         = 1250,
    parameter int unsigned TLATCH_US       = 80
) (
    input  logic          Clock,
    input  logic          Reset,
    ws2812_chain_if.slave bus
);
    localparam int unsigned AW         = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam int unsigned MHZ        = CLOCK_FREQUENCY / 1000000;
    localparam int unsigned T0H_CYC    = MHZ * T0H_NS / 1000;
    localparam int unsigned T1H_CYC    = MHZ * T1H_NS / 1000;
    localparam int unsigned TBIT_CYC   = MHZ * TBIT_NS / 1000;
    localparam int unsigned TLATCH_CYC = MHZ * TLATCH_US;
    localparam int unsigned CW         = (TBIT_CYC > 1) ? $clog2(TBIT_CYC) : 1;
    localparam int unsigned LW         = (TLATCH_CYC > 1) ? $clog2(TLATCH_CYC) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SEND  = 2'd1,
        S_LATCH = 2'd2
    } state_t;

    state_t          r_state, w_state;
    logic [CW-1:0]   r_cyc, w_cyc;
    logic [4:0]      r_bit_idx, w_bit_idx;
    logic [AW-1:0]   r_led_idx, w_led_idx;
    logic [AW-1:0]   w_load_idx;
    logic [23:0]     r_shift, w_shift;
    logic [23:0]     w_pix;
    logic [7:0]      r_bright, w_bright;
    logic [LW-1:0]   r_latch_cnt, w_latch_cnt;
    logic            r_led, w_led;
    logic            r_ready, w_ready;
    logic            r_done, w_done;
    logic            w_do_load;
    int unsigned     w_hi;

    logic [23:0]     r_buf [NUM_LEDS];

    // c' = (c * (b + 1)) >> 8, so b = 255 is transparent and b = 0 blanks
    function automatic logic [7:0] f_scale(input logic [7:0] c, input logic [7:0] b);
        logic [15:0] p;
        p = 16'(c) * (16'(b) + 16'd1);
        return 8'(p >> 8);
    endfunction

    // Frame buffer: no reset, contents survive Reset
    always_ff @(posedge Clock) begin
        if (bus.i_Wr_En && (32'(bus.i_Wr_Addr) < NUM_LEDS))
            r_buf[AW'(bus.i_Wr_Addr)] <= bus.i_Wr_Data;
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state     <= S_IDLE;
            r_cyc       <= '0;
            r_bit_idx   <= '0;
            r_led_idx   <= '0;
            r_shift     <= '0;
            r_bright    <= '0;
            r_latch_cnt <= '0;
            r_led       <= 1'b0;
            r_ready     <= 1'b1;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_cyc       <= w_cyc;
            r_bit_idx   <= w_bit_idx;
            r_led_idx   <= w_led_idx;
            r_shift     <= w_shift;
            r_bright    <= w_bright;
            r_latch_cnt <= w_latch_cnt;
            r_led       <= w_led;
            r_ready     <= w_ready;
            r_done      <= w_done;
        end
    end

    always_comb begin
        w_state     = r_state;
        w_cyc       = r_cyc;
        w_bit_idx   = r_bit_idx;
        w_led_idx   = r_led_idx;
        w_shift     = r_shift;
        w_bright    = r_bright;
        w_latch_cnt = r_latch_cnt;
        w_led       = 1'b0;
        w_ready     = r_ready;
        w_load_idx  = '0;
        w_do_load   = 1'b0;
        w_hi        = r_shift[23] ? T1H_CYC : T0H_CYC;

        case (r_state)
            S_IDLE: begin
                w_ready = 1'b1;
                if (bus.i_Start) begin
                    w_do_load = 1'b1;
                    w_bright  = bus.i_Brightness;
                    w_led_idx = '0;
                    w_state   = S_SEND;
                    w_ready   = 1'b0;
                end
            end
            S_SEND: begin
                if (32'(r_cyc) == TBIT_CYC - 1) begin
                    w_cyc = '0;
                    if (r_bit_idx == 5'd0) begin
                        if (32'(r_led_idx) == NUM_LEDS - 1) begin
                            w_state     = S_LATCH;
                            w_latch_cnt = '0;
                        end else begin
                            w_do_load  = 1'b1;
                            w_load_idx = r_led_idx + AW'(1);
                            w_led_idx  = r_led_idx + AW'(1);
                        end
                    end else begin
                        w_bit_idx = r_bit_idx - 5'd1;
                        w_shift   = {r_shift[22:0], 1'b0};
                        w_led     = 1'b1;
                    end
                end else begin
                    w_cyc = r_cyc + CW'(1);
                    w_led = (32'(r_cyc) + 1) < w_hi;
                end
            end
            S_LATCH: begin
                if (32'(r_latch_cnt) == TLATCH_CYC - 1) begin
                    if (bus.i_Auto || bus.i_Start) begin
                        w_do_load = 1'b1;
                        w_bright  = bus.i_Brightness;
                        w_led_idx = '0;
                        w_state   = S_SEND;
                    end else begin
                        w_state = S_IDLE;
                        w_ready = 1'b1;
                    end
                end else begin
                    w_latch_cnt = r_latch_cnt + LW'(1);
                end
            end
            default: begin
                w_state = S_IDLE;
                w_ready = 1'b1;
            end
        endcase

        // Load reads the buffer before any same-cycle write lands
        w_pix = r_buf[w_load_idx];
        if (w_do_load) begin
            w_shift   = {f_scale(w_pix[23:16], w_bright),
                         f_scale(w_pix[15:8],  w_bright),
                         f_scale(w_pix[7:0],   w_bright)};
            w_bit_idx = 5'd23;
            w_cyc     = '0;
            w_led     = 1'b1;
        end

        w_done = (w_state == S_LATCH) && (32'(w_latch_cnt) == TLATCH_CYC - 1);
    end

    assign bus.o_Led        = r_led;
    assign bus.o_Ready      = r_ready;
    assign bus.o_Frame_Done = r_done;
endmodule

// File: tb/tb_ws2812_chain.sv
// Directed bench for ws2812_chain: NUM_LEDS=2 at 80 MHz, decodes the serial stream per frame.
module tb_ws2812_chain;
    logic Clock = 1'b0;
    logic Reset;

    always #5 Clock = ~Clock;

    ws2812_chain_if #(.AW(1)) bus ();

    ws2812_chain #(
        .CLOCK_FREQUENCY(80000000),
        .NUM_LEDS       (2),
        .T0H_NS         (400),
        .T1H_NS         (800),
        .TBIT_NS        (1250),
        .TLATCH_US      (80)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .bus  (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [47:0] f_bits;
    int f_bad, f_hi0, f_hi23, f_done_at, f_done_cnt, f_latch_hi, f_rdy_hi;
    int cnt;

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic addr, input logic [23:0] d);
        @(negedge Clock);
        bus.i_Wr_En   = 1'b1;
        bus.i_Wr_Addr = addr;
        bus.i_Wr_Data = d;
        @(negedge Clock);
        bus.i_Wr_En   = 1'b0;
    endtask

    // Samples one full frame (48 bits x 100 cycles + 6400 latch cycles), cycle 1 = first bit cycle
    task automatic run_frame(input bit do_start, output logic [47:0] bits, output int bad,
                             output int hi0, output int hi23, output int done_at,
                             output int done_cnt, output int latch_hi, output int rdy_hi);
        int hi;
        bit seen_lo;
        bits = '0; bad = 0; hi0 = 0; hi23 = 0;
        done_at = 0; done_cnt = 0; latch_hi = 0; rdy_hi = 0;
        if (do_start) begin
            @(negedge Clock);
            bus.i_Start = 1'b1;
            @(posedge Clock);
            #1 bus.i_Start = 1'b0;
        end
        for (int b = 0; b < 48; b++) begin
            hi = 0;
            seen_lo = 1'b0;
            for (int k = 0; k < 100; k++) begin
                @(negedge Clock);
                if (bus.o_Led === 1'b1) begin
                    hi++;
                    if (seen_lo) bad++;
                end else begin
                    seen_lo = 1'b1;
                end
                if (bus.o_Ready !== 1'b0) rdy_hi++;
                if (bus.o_Frame_Done !== 1'b0) done_cnt++;
            end
            if (hi != 32 && hi != 64) bad++;
            bits[47-b] = (hi > 48);
            if (b == 0) hi0 = hi;
            if (b == 23) hi23 = hi;
        end
        for (int c = 4801; c <= 11200; c++) begin
            @(negedge Clock);
            if (bus.o_Led !== 1'b0) latch_hi++;
            if (bus.o_Ready !== 1'b0) rdy_hi++;
            if (bus.o_Frame_Done === 1'b1) begin
                done_cnt++;
                if (done_at == 0) done_at = c;
            end
        end
    endtask

    task automatic chk_frame(input string tag, input logic [47:0] exp_bits);
        chk({tag, "_bits"},      f_bits,             exp_bits);
        chk({tag, "_shape"},     48'(f_bad),         48'd0);
        chk({tag, "_done_at"},   48'(f_done_at),     48'd11200);
        chk({tag, "_done_cnt"},  48'(f_done_cnt),    48'd1);
        chk({tag, "_latch_low"}, 48'(f_latch_hi),    48'd0);
        chk({tag, "_ready_low"}, 48'(f_rdy_hi),      48'd0);
    endtask

    initial begin
        Reset            = 1'b1;
        bus.i_Wr_En      = 1'b0;
        bus.i_Wr_Addr    = '0;
        bus.i_Wr_Data    = '0;
        bus.i_Brightness = 8'd255;
        bus.i_Start      = 1'b0;
        bus.i_Auto       = 1'b0;

        repeat (3) @(negedge Clock);
        chk("rst_led",   48'(bus.o_Led),        48'd0);
        chk("rst_ready", 48'(bus.o_Ready),      48'd1);
        chk("rst_done",  48'(bus.o_Frame_Done), 48'd0);
        Reset = 1'b0;

        // Basic frame
        wr(1'b0, 24'h800001);
        wr(1'b1, 24'h000000);
        chk("idle_ready", 48'(bus.o_Ready), 48'd1);
        run_frame(1'b1, f_bits, f_bad, f_hi0, f_hi23, f_done_at, f_done_cnt, f_latch_hi, f_rdy_hi);
        chk_frame("basic", 48'h800001_000000);
        chk("basic_hi_first", 48'(f_hi0),  48'd64);
        chk("basic_hi_bit23", 48'(f_hi23), 48'd64);
        @(negedge Clock);
        chk("basic_ready_after", 48'(bus.o_Ready), 48'd1);
        chk("basic_led_after",   48'(bus.o_Led),   48'd0);

        // Auto mode, brightness 127 then 255 then 0; writes during frame 2
        wr(1'b0, 24'hFF8040);
        bus.i_Brightness = 8'd127;
        bus.i_Auto       = 1'b1;
        fork
            run_frame(1'b1, f_bits, f_bad, f_hi0, f_hi23, f_done_at, f_done_cnt, f_latch_hi, f_rdy_hi);
            begin
                repeat (2000) @(negedge Clock);
                bus.i_Brightness = 8'd255;
            end
        join
        chk_frame("auto1_b127", 48'h7F4020_000000);

        fork
            run_frame(1'b0, f_bits, f_bad, f_hi0, f_hi23, f_done_at, f_done_cnt, f_latch_hi, f_rdy_hi);
            begin
                repeat (500) @(negedge Clock);
                wr(1'b1, 24'h00FF00);
                wr(1'b0, 24'h0000FF);
                repeat (3000) @(negedge Clock);
                bus.i_Brightness = 8'd0;
            end
        join
        chk_frame("auto2_wr", 48'hFF8040_00FF00);

        fork
            run_frame(1'b0, f_bits, f_bad, f_hi0, f_hi23, f_done_at, f_done_cnt, f_latch_hi, f_rdy_hi);
            begin
                repeat (1000) @(negedge Clock);
                bus.i_Auto = 1'b0;
            end
        join
        chk_frame("auto3_b0", 48'h000000_000000);
        @(negedge Clock);
        chk("auto_end_ready", 48'(bus.o_Ready), 48'd1);

        // Start while busy is ignored; next frame shows the LED0 write
        bus.i_Brightness = 8'd255;
        fork
            run_frame(1'b1, f_bits, f_bad, f_hi0, f_hi23, f_done_at, f_done_cnt, f_latch_hi, f_rdy_hi);
            begin
                repeat (300) @(negedge Clock);
                bus.i_Start = 1'b1;
                @(negedge Clock);
                bus.i_Start = 1'b0;
            end
        join
        chk_frame("busy", 48'h0000FF_00FF00);
        cnt = 0;
        repeat (200) begin
            @(negedge Clock);
            if (bus.o_Led !== 1'b0 || bus.o_Ready !== 1'b1) cnt++;
        end
        chk("busy_no_second_frame", 48'(cnt), 48'd0);

        // Reset mid-frame
        @(negedge Clock);
        bus.i_Start = 1'b1;
        @(posedge Clock);
        #1 bus.i_Start = 1'b0;
        repeat (205) @(negedge Clock);
        chk("pre_reset_led", 48'(bus.o_Led), 48'd1);
        #1 Reset = 1'b1;
        #1;
        chk("reset_led_async",   48'(bus.o_Led),   48'd0);
        chk("reset_ready_async", 48'(bus.o_Ready), 48'd1);
        cnt = 0;
        repeat (3) begin
            @(negedge Clock);
            if (bus.o_Frame_Done !== 1'b0) cnt++;
        end
        chk("reset_no_done", 48'(cnt), 48'd0);
        Reset = 1'b0;
        @(negedge Clock);
        chk("post_reset_ready", 48'(bus.o_Ready), 48'd1);
        run_frame(1'b1, f_bits, f_bad, f_hi0, f_hi23, f_done_at, f_done_cnt, f_latch_hi, f_rdy_hi);
        chk_frame("post_reset", 48'h0000FF_00FF00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
